// File: rtl/storage_req_bridge_if.sv
// Bundles the core-side req/gnt/rvalid bus and the storage-controller access bus.
// The bridge connects through the slave modport; whoever drives the core and controller sides uses master.
interface storage_req_bridge_if #(
    parameter int MEM_W = 32
);
    // Core side
    logic               mem_req;
    logic               mem_gnt;
    logic               mem_we;
    logic [MEM_W/8-1:0] mem_be;
    logic [31:0]        mem_addr;
    logic [MEM_W-1:0]   mem_wdata;
    logic               mem_rvalid;
    logic [MEM_W-1:0]   mem_rdata;
    logic               mem_err;

    // Storage controller side
    logic               sc_memory_access;
    logic               sc_memory_is_writing;
    logic [31:0]        sc_addr;
    logic [MEM_W-1:0]   sc_d_in;
    logic [MEM_W/8-1:0] sc_mem_be;
    logic [MEM_W-1:0]   sc_d_out;
    logic               sc_out_valid;

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output sc_memory_access, sc_memory_is_writing, sc_addr, sc_d_in, sc_mem_be,
        input  sc_d_out, sc_out_valid
    );

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  sc_memory_access, sc_memory_is_writing, sc_addr, sc_d_in, sc_mem_be,
        output sc_d_out, sc_out_valid
    );
endinterface

// File: rtl/storage_req_bridge.sv
// Converts the core's pipelined req/gnt/rvalid bus into the storage controller's level-held access protocol.
// Optional watchdog on controller accesses: define STORAGE_REQ_BRIDGE_TIMEOUT_EN.
module storage_req_bridge #(
    parameter int          MEM_W          = 32,
    parameter int          FIFO_DEPTH     = 2,
    parameter logic [31:0] SRAM_LIMIT     = 32'h0000_0FFF,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    storage_req_bridge_if.slave bus,
    output logic [1:0]          dbg_state
);
    // Handshake: a request transfers on a cycle where mem_req && mem_gnt; mem_gnt
    // depends only on mem_req and queue occupancy. Each transferred request gets
    // exactly one mem_rvalid pulse, in transfer order; mem_rdata/mem_err are
    // meaningful only while mem_rvalid is high. On the controller side,
    // sc_memory_access stays high with stable fields until sc_out_valid is seen.

    localparam int BE_W  = MEM_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic             we;
        logic [BE_W-1:0]  be;
        logic [31:0]      addr;
        logic [MEM_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        GAP      = 2'd2,
        ERR_RESP = 2'd3
    } state_e;

    // Request queue
    req_t             fifo_mem_q [FIFO_DEPTH];
    req_t             fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    req_t             push_entry;
    req_t             head;
    logic             head_illegal;

    // Control and response registers
    state_e           state_q, state_d;
    logic             access_q, access_d;
    logic             writing_q, writing_d;
    logic [31:0]      addr_q, addr_d;
    logic [MEM_W-1:0] d_in_q, d_in_d;
    logic [BE_W-1:0]  be_q, be_d;
    logic             rvalid_q, rvalid_d;
    logic [MEM_W-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

`ifdef STORAGE_REQ_BRIDGE_TIMEOUT_EN
    localparam int           TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign fifo_full    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign bus.mem_gnt  = bus.mem_req & ~fifo_full;
    assign push         = bus.mem_req & ~fifo_full;
    assign head         = fifo_mem_q[rd_ptr_q];

    // Misaligned, or a write into the read-only flash window
    assign head_illegal = (head.addr[1:0] != 2'b00) ||
                          (head.we && (head.addr >= SRAM_LIMIT));

    always_comb begin
        push_entry.we    = bus.mem_we;
        push_entry.be    = bus.mem_be;
        push_entry.addr  = bus.mem_addr;
        push_entry.wdata = bus.mem_wdata;
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        access_d  = access_q;
        writing_d = writing_q;
        addr_d    = addr_q;
        d_in_d    = d_in_q;
        be_d      = be_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
`ifdef STORAGE_REQ_BRIDGE_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_illegal) begin
                        state_d = ERR_RESP;
                    end else begin
                        access_d  = 1'b1;
                        writing_d = head.we;
                        addr_d    = head.addr;
                        d_in_d    = head.wdata;
                        be_d      = head.be;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.sc_out_valid) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = writing_q ? '0 : bus.sc_d_out;
                    access_d  = 1'b0;
                    writing_d = 1'b0;
                    addr_d    = '0;
                    d_in_d    = '0;
                    be_d      = '0;
                    state_d   = GAP;
                end
`ifdef STORAGE_REQ_BRIDGE_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    rvalid_d  = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = MEM_W'(32'hDEAD_BEEF);
                    access_d  = 1'b0;
                    writing_d = 1'b0;
                    addr_d    = '0;
                    d_in_d    = '0;
                    be_d      = '0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`else
                // Without the watchdog the controller is waited on indefinitely.
`endif
            end
            // One cycle with access low lets the controller fall back to its default state
            GAP: begin
                state_d = IDLE;
            end
            ERR_RESP: begin
                rvalid_d = 1'b1;
                err_d    = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            access_q  <= 1'b0;
            writing_q <= 1'b0;
            addr_q    <= '0;
            d_in_q    <= '0;
            be_q      <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            access_q  <= access_d;
            writing_q <= writing_d;
            addr_q    <= addr_d;
            d_in_q    <= d_in_d;
            be_q      <= be_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef STORAGE_REQ_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign bus.sc_memory_access     = access_q;
    assign bus.sc_memory_is_writing = writing_q;
    assign bus.sc_addr              = addr_q;
    assign bus.sc_d_in              = d_in_q;
    assign bus.sc_mem_be            = be_q;
    assign bus.mem_rvalid           = rvalid_q;
    assign bus.mem_rdata            = rdata_q;
    assign bus.mem_err              = err_q;
    assign dbg_state                = state_q;
endmodule

// File: tb/tb_storage_req_bridge.sv
// Directed bench for storage_req_bridge: vector table for single accesses plus
// hand-written sequences for back-to-back queueing, mid-access reset and the watchdog.
module tb_storage_req_bridge;
    localparam int MEM_W  = 32;
    localparam int TO_CYC = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    storage_req_bridge_if #(.MEM_W(MEM_W)) bus ();
    logic [1:0] dbg_state;

    storage_req_bridge #(
        .MEM_W(MEM_W),
        .FIFO_DEPTH(2),
        .SRAM_LIMIT(32'h0000_0FFF),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // controller cycles of access before out_valid
        logic [31:0] base;      // controller returns base ^ sc_addr
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;   // grant cycle to mem_rvalid cycle
        int          exp_acc;   // cycles with sc_memory_access high
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [MEM_W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Controller model
    int          ctrl_lat  = 1;
    logic [31:0] ctrl_base = '0;
    int          m_cnt     = 0;
    logic        m_done    = 1'b0;

    initial begin
        bus.sc_out_valid = 1'b0;
        bus.sc_d_out     = '0;
    end

    always @(negedge clk) begin
        bus.sc_out_valid = 1'b0;
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (bus.sc_memory_access === 1'b1) begin
            if (!m_done) begin
                m_cnt++;
                if (ctrl_lat != 0 && m_cnt == ctrl_lat + 1) begin
                    bus.sc_out_valid = 1'b1;
                    bus.sc_d_out     = ctrl_base ^ bus.sc_addr;
                    m_done           = 1'b1;
                end
            end
        end else begin
            m_cnt  = 0;
            m_done = 1'b0;
        end
    end

    // Monitor and scoreboard
    logic        mon_en     = 1'b0;
    logic        prev_acc   = 1'b0;
    logic [68:0] prev_f     = '0;
    int          acc_cnt    = 0;
    int          zero_err   = 0;
    int          stable_err = 0;
    int          last_rv    = 0;
    int          gap_cnt    = 0;
    int          gap_min    = 1000;
    logic        seen_fall  = 1'b0;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_din;

    always @(negedge clk) begin
        logic [68:0] f;
        logic [MEM_W:0] e;
        if (mon_en) begin
            f = {bus.sc_memory_is_writing, bus.sc_mem_be, bus.sc_addr, bus.sc_d_in};
            if (bus.sc_memory_access === 1'b1) begin
                acc_cnt++;
                if (!prev_acc) begin
                    cap_we   = bus.sc_memory_is_writing;
                    cap_be   = bus.sc_mem_be;
                    cap_addr = bus.sc_addr;
                    cap_din  = bus.sc_d_in;
                    if (seen_fall && gap_cnt < gap_min) gap_min = gap_cnt;
                end else if (f !== prev_f) begin
                    stable_err++;
                end
            end else begin
                if (f !== '0) zero_err++;
                if (prev_acc) begin
                    seen_fall = 1'b1;
                    gap_cnt   = 1;
                end else begin
                    gap_cnt++;
                end
            end
            if (bus.mem_rvalid === 1'b1) begin
                last_rv = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rvalid: got rvalid with rdata %0h err %0b, required no response",
                             bus.mem_rdata, bus.mem_err);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {bus.mem_err, bus.mem_rdata}, e);
                end
            end
            prev_acc = (bus.sc_memory_access === 1'b1);
            prev_f   = f;
        end
    end

    // Driver tasks
    task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int gcyc);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_be    = be;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        gcyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mem_gnt === 1'b1) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            n_checks++;
            $display("FAIL grant_timeout: addr %0h never granted, required a grant", addr);
        end
        @(posedge clk);
        #1;
        bus.mem_req = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        int g, ga, gb, gc, gd;
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int g, ga, gb, gc, gd;
        vecs[0] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1, 32'h1234_5668, 1'b0, 32'h1234_5678, 4, 2};
        vecs[1] = '{1'b1, 4'h3, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF, 1'b0, 32'h0,         4, 2};
        vecs[2] = '{1'b1, 4'hF, 32'h0000_2000, 32'h1111_2222, 1, 32'h0,         1'b1, 32'h0,         3, 0};
        vecs[3] = '{1'b0, 4'hF, 32'h0000_0006, 32'h0,         1, 32'h0,         1'b1, 32'h0,         3, 0};
        vecs[4] = '{1'b0, 4'hF, 32'h0000_2000, 32'h0,         3, 32'hA5A5_2001, 1'b0, 32'hA5A5_0001, 6, 4};
        vecs[5] = '{1'b1, 4'hC, 32'h0000_0FFC, 32'h5A5A_5A5A, 2, 32'h0,         1'b0, 32'h0,         5, 3};
        vecs[6] = '{1'b1, 4'hF, 32'h0000_1000, 32'h3333_4444, 1, 32'h0,         1'b1, 32'h0,         3, 0};
        vecs[7] = '{1'b0, 4'hF, 32'h0000_0001, 32'h0,         1, 32'h0,         1'b1, 32'h0,         3, 0};
        vecs[8] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         1, 32'h0BAD_C502, 1'b0, 32'h0BAD_CAFE, 4, 2};

        // Clock/reset
        rst           = 1'b1;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp", {bus.mem_gnt, bus.mem_rvalid, bus.mem_err, bus.mem_rdata}, '0);
        check("reset_access", bus.sc_memory_access, 1'b0);
        check("reset_sc_fields", {bus.sc_memory_is_writing, bus.sc_mem_be, bus.sc_addr, bus.sc_d_in}, '0);
        check("reset_state", dbg_state, 2'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single accesses from the table
        for (int i = 0; i < 9; i++) begin
            ctrl_lat  = vecs[i].lat;
            ctrl_base = vecs[i].base;
            acc_cnt   = 0;
            cap_we    = 1'bx;
            cap_be    = 'x;
            cap_addr  = 'x;
            cap_din   = 'x;
            exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
            send(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, g);
            wait_drain($sformatf("v%0d_drain", i));
            check($sformatf("v%0d_latency", i), last_rv - g, vecs[i].exp_lat);
            check($sformatf("v%0d_access_cycles", i), acc_cnt, vecs[i].exp_acc);
            if (vecs[i].exp_acc != 0) begin
                check($sformatf("v%0d_sc_we", i), cap_we, vecs[i].we);
                check($sformatf("v%0d_sc_be", i), cap_be, vecs[i].be);
                check($sformatf("v%0d_sc_addr", i), cap_addr, vecs[i].addr);
                check($sformatf("v%0d_sc_d_in", i), cap_din, vecs[i].wdata);
            end
        end

        // Back-to-back reads with a slow controller: the fourth stalls on a full queue
        ctrl_lat  = 20;
        ctrl_base = 32'h7700_0000;
        gap_min   = 1000;
        seen_fall = 1'b0;
        exp_q.push_back({1'b0, 32'h7700_0000});
        exp_q.push_back({1'b0, 32'h7700_0004});
        exp_q.push_back({1'b0, 32'h7700_0008});
        exp_q.push_back({1'b0, 32'h7700_000C});
        send(1'b0, 4'hF, 32'h0000_0000, 32'h0, ga);
        send(1'b0, 4'hF, 32'h0000_0004, 32'h0, gb);
        send(1'b0, 4'hF, 32'h0000_0008, 32'h0, gc);
        send(1'b0, 4'hF, 32'h0000_000C, 32'h0, gd);
        check("b2b_grant_b", gb - ga, 1);
        check("b2b_grant_c", gc - ga, 2);
        check("b2b_grant_d_stalled", gd - ga, 25);
        wait_drain("b2b_drain");
        check("b2b_idle_gap", gap_min, 2);

        // Reset while the controller holds an access, with a second entry queued
        ctrl_lat = 0;
        send(1'b0, 4'hF, 32'h0000_0040, 32'h0, g);
        send(1'b0, 4'hF, 32'h0000_0044, 32'h0, g);
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_pre_access", bus.sc_memory_access, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_access", bus.sc_memory_access, 1'b0);
        check("rst_mid_state", dbg_state, 2'd0);
        check("rst_mid_rvalid", bus.mem_rvalid, 1'b0);
        acc_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid_queue_empty", acc_cnt, 0);
        ctrl_lat  = 1;
        ctrl_base = 32'h1111_0000;
        exp_q.push_back({1'b0, 32'h1111_0100});
        send(1'b0, 4'hF, 32'h0000_0100, 32'h0, g);
        wait_drain("rst_after_drain");
        check("rst_after_latency", last_rv - g, 4);

`ifdef STORAGE_REQ_BRIDGE_TIMEOUT_EN
        // Controller never answers the first read; the queued second one completes normally
        ctrl_lat  = 0;
        ctrl_base = 32'h2222_0000;
        acc_cnt   = 0;
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        exp_q.push_back({1'b0, 32'h2222_0084});
        send(1'b0, 4'hF, 32'h0000_0080, 32'h0, ga);
        send(1'b0, 4'hF, 32'h0000_0084, 32'h0, gb);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() < 2) break;
            @(negedge clk);
        end
        ctrl_lat = 1;
        @(posedge clk);
        #1;
        check("timeout_latency", last_rv - ga, 18);
        check("timeout_access_cycles", acc_cnt, 16);
        wait_drain("timeout_drain");
`endif

        check("sc_zero_when_idle", zero_err, 0);
        check("sc_stable_during_access", stable_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
